// File: rtl/pipelined_rca_adder.sv
// -----------------------------------------------------------------------------
// pipelined_rca_adder
//
// Streaming adder/subtractor built from chained single-bit full-adder cells.
// The WIDTH-bit operands are cut into STAGES segments of SEG bits. Each stage
// ripples one segment and registers its carry into the next stage. The
// critical route is therefore SEG full-adder delays instead of WIDTH.
//
// Each stage register r_a holds one word. Its low bits are sum segments that
// are already finished, and its high bits are operand-A bits still waiting for
// their stage. This one register does both the A skew and the sum deskew.
// Pending operand-B bits travel in a separate shrinking skew register
// (r_b_up). The MSBs of A and of the conditioned B ride alongside the data so
// that the overflow flag can be formed at the output.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset; clears every register
//   en         in   pipeline advance enable; 0 freezes every register
//   in_valid   in   A/B/Cin/sub carry an operation this cycle
//   A, B       in   WIDTH-bit operands (unsigned or two's complement)
//   Cin        in   carry-in (add) / borrow-in (sub)
//   sub        in   0 = A + B + Cin, 1 = A - B - Cin
//   out_valid  out  S/Cout/ovf hold a result
//   S          out  sum / difference, modulo 2^WIDTH
//   Cout       out  carry-out (add) / not-borrow (sub)
//   ovf        out  signed two's-complement overflow
//
// Latency is STAGES enabled cycles. Throughput is one operation per enabled
// cycle.
// -----------------------------------------------------------------------------
module pipelined_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_rca_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  // One full-adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  // Subtraction is A + ~B + 1. The borrow-in is folded into the inverted
  // carry-in, so sub with Cin=1 yields A - B - 1.
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  assign w_b_eff = sub ? ~B : B;
  assign w_c0    = sub ? ~Cin : Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;      // first bit rippled by this stage
    localparam int BW = WIDTH - LO;   // operand-B bits still pending on entry

    logic [WIDTH-1:0] w_a_in;
    logic [BW-1:0]    w_b_in;         // w_b_in[0] is bit LO of the conditioned B
    logic             w_c_in;
    logic             w_v_in;
    logic             w_amsb_in;
    logic             w_bmsb_in;
    logic [WIDTH-1:0] w_a_next;
    logic             w_c_out;

    logic [WIDTH-1:0] r_a;
    logic             r_c;
    logic             r_v;
    logic             r_amsb;
    logic             r_bmsb;

    if (k == 0) begin : g_head
      assign w_a_in    = A;
      assign w_b_in    = w_b_eff;
      assign w_c_in    = w_c0;
      assign w_v_in    = in_valid;
      assign w_amsb_in = A[MSB];
      assign w_bmsb_in = w_b_eff[MSB];
    end else begin : g_link
      assign w_a_in    = g_stage[k-1].r_a;
      assign w_b_in    = g_stage[k-1].g_skew.r_b_up;
      assign w_c_in    = g_stage[k-1].r_c;
      assign w_v_in    = g_stage[k-1].r_v;
      assign w_amsb_in = g_stage[k-1].r_amsb;
      assign w_bmsb_in = g_stage[k-1].r_bmsb;
    end

    // Ripple this stage's segment. Every other bit of the word passes through
    // unchanged: finished sum bits below, pending A bits above.
    always_comb begin : p_ripple
      logic carry;
      // NOTE: every combinational output gets a full default before any
      // partial update; a path that skips an assignment would infer a latch.
      w_a_next = w_a_in;
      carry    = w_c_in;
      for (int i = 0; i < SEG; i++) begin
        {carry, w_a_next[LO+i]} = full_adder(w_a_in[LO+i], w_b_in[i], carry);
      end
      w_c_out = carry;
    end

    // The last stage consumes the remaining B bits itself, so it needs no skew.
    if (k < STAGES - 1) begin : g_skew
      logic [BW-SEG-1:0] r_b_up;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_b_up <= '0;
        end else if (en) begin
          r_b_up <= w_b_in[BW-1:SEG];
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value. Data registers are reset along
    // with valid because the outputs must read zero during and after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a    <= '0;
        r_c    <= 1'b0;
        r_v    <= 1'b0;
        r_amsb <= 1'b0;
        r_bmsb <= 1'b0;
      end else if (en) begin
        r_a    <= w_a_next;
        r_c    <= w_c_out;
        r_v    <= w_v_in;
        r_amsb <= w_amsb_in;
        r_bmsb <= w_bmsb_in;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign S         = g_stage[STAGES-1].r_a;
  assign Cout      = g_stage[STAGES-1].r_c;
  // Overflow: both operands have the same sign and the result's sign differs.
  assign ovf       = (g_stage[STAGES-1].r_amsb == g_stage[STAGES-1].r_bmsb) &&
                     (S[MSB] != g_stage[STAGES-1].r_amsb);

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_rca_adder
//
// Directed checks on a WIDTH=16, STAGES=4 instance: reset, latency, full carry
// ripple, signed overflow, borrow, streaming truth table, stall and mid-stream
// reset. Three further instances, (8,1), (8,8) and (32,4), each run a random
// add/sub stream against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_pipelined_rca_adder;

  localparam int N_RAND = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        sweep_go;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipelined_rca_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .S         (s),
    .Cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: returns {ovf, cout, s[63:0]}.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic ci,
                                          input logic sb);
    logic [63:0] mask;
    logic [63:0] be;
    logic [64:0] full;
    logic [63:0] sum;
    logic        co;
    logic        ov;
    mask = (64'd1 << w) - 64'd1;
    be   = (sb ? ~bv : bv) & mask;
    full = {1'b0, av & mask} + {1'b0, be} + {64'd0, sb ^ ci};
    sum  = full[63:0] & mask;
    co   = full[w];
    ov   = (av[w-1] == be[w-1]) && (sum[w-1] != av[w-1]);
    return {ov, co, sum};
  endfunction

  task automatic set_in(input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, input logic v);
    a        = av;
    b        = bv;
    cin      = ci;
    sub      = sb;
    in_valid = v;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] es,
                           input logic ec, input logic eo);
    check({tag, "_valid"}, out_valid, v);
    check({tag, "_s"}, s, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  // Single operation into an empty pipeline; the result must appear on
  // exactly the fourth edge.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo);
    @(negedge clk);
    set_in(av, bv, ci, sb, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) check($sformatf("%s_lat%0d", tag, c), out_valid, 1'b0);
      else       check_out(tag, 1'b1, es, ec, eo);
      in_valid = 1'b0;
    end
  endtask

  // Random streams on other geometries.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W  = (g == 2) ? 32 : 8;
    localparam int ST = (g == 0) ? 1 : ((g == 1) ? 8 : 4);

    logic [W-1:0] sa;
    logic [W-1:0] sb;
    logic [W-1:0] ss;
    logic         scin;
    logic         ssub;
    logic         sin_valid;
    logic         sout_valid;
    logic         scout;
    logic         sovf;
    logic         done;

    pipelined_rca_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (1'b1),
      .in_valid  (sin_valid),
      .A         (sa),
      .B         (sb),
      .Cin       (scin),
      .sub       (ssub),
      .out_valid (sout_valid),
      .S         (ss),
      .Cout      (scout),
      .ovf       (sovf)
    );

    initial begin
      logic [65:0] exp_q[$];
      int          cyc_q[$];
      logic [65:0] e;
      int          issued;
      int          got;
      int          cyc;
      int          t0;
      done      = 1'b0;
      sin_valid = 1'b0;
      sa        = '0;
      sb        = '0;
      scin      = 1'b0;
      ssub      = 1'b0;
      issued    = 0;
      got       = 0;
      cyc       = 0;
      wait (sweep_go);
      while (got < N_RAND && cyc < N_RAND + 100) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          check($sformatf("sw%0d_idle_valid", g), sout_valid, 1'b0);
        end else if (sout_valid) begin
          e  = exp_q.pop_front();
          t0 = cyc_q.pop_front();
          check($sformatf("sw%0d_s", g), 64'(ss), e[63:0]);
          check($sformatf("sw%0d_cout", g), scout, e[64]);
          check($sformatf("sw%0d_ovf", g), sovf, e[65]);
          check($sformatf("sw%0d_latency", g), 64'(cyc - t0), 64'(ST));
          got++;
        end
        if (issued < N_RAND) begin
          sa        = W'($urandom);
          sb        = W'($urandom);
          scin      = 1'($urandom);
          ssub      = 1'($urandom);
          sin_valid = 1'b1;
          exp_q.push_back(ref_add(W, 64'(sa), 64'(sb), scin, ssub));
          cyc_q.push_back(cyc);
          issued++;
        end else begin
          sin_valid = 1'b0;
        end
        cyc++;
      end
      check($sformatf("sw%0d_count", g), 64'(got), 64'(N_RAND));
      done = 1'b1;
    end
  end

  // Streaming truth table: index bits {A, B, Cin}, replicated over all bits.
  logic [15:0] tt_s [8] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0000,
                            16'hFFFF, 16'h0000, 16'hFFFE, 16'hFFFF};
  logic        tt_c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  // Stall sequence operands and hand-computed results.
  logic [15:0] st_a [4] = '{16'h1111, 16'h1234, 16'hF000, 16'h0010};
  logic [15:0] st_b [4] = '{16'h2222, 16'h4321, 16'h1000, 16'h0001};
  logic        st_u [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] st_s [4] = '{16'h3333, 16'h5555, 16'h0000, 16'h000F};
  logic        st_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rv;
    rst_n    = 1'b0;
    en       = 1'b1;
    sweep_go = 1'b0;
    set_in(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_valid", out_valid, 1'b0);

    // Directed single operations.
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("borrow0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("borrow1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);

    // Back-to-back truth table: result i appears 4 cycles after issue i.
    for (int t = 0; t <= 12; t++) begin
      @(negedge clk);
      if (t >= 4 && t < 12) check_out($sformatf("tt%0d", t - 4), 1'b1, tt_s[t-4], tt_c[t-4], 1'b0);
      if (t == 12) check("tt_drain_valid", out_valid, 1'b0);
      if (t < 8) set_in(t[2] ? 16'hFFFF : 16'h0000, t[1] ? 16'hFFFF : 16'h0000, t[0], 1'b0, 1'b1);
      else       in_valid = 1'b0;
    end

    // Stall: four ops in flight, en low for three edges with junk on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_in(st_a[i], st_b[i], 1'b0, st_u[i], 1'b1);
    end
    @(negedge clk);
    check_out("stall_first", 1'b1, st_s[0], st_c[0], 1'b0);
    en = 1'b0;
    set_in(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_out($sformatf("stall_hold%0d", j), 1'b1, st_s[0], st_c[0], 1'b0);
    end
    en       = 1'b1;
    in_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      check_out($sformatf("stall_resume%0d", j), 1'b1, st_s[j], st_c[j], 1'b0);
    end
    @(negedge clk);
    check("stall_drain_valid", out_valid, 1'b0);

    // Mid-stream reset with operations in flight and a result on the output.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rv = 16'h0101 * 16'(i + 1);
      set_in(rv, rv, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_out("prereset", 1'b1, 16'h0404, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("after_reset_valid%0d", j), out_valid, 1'b0);
    end

    // Random sweeps on the other geometries.
    sweep_go = 1'b1;
    for (int i = 0; i < 3000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); i++) begin
      @(negedge clk);
    end
    check("sweeps_done", {g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 3'b111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
